// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, UART-side write/read polarity and
// the arbiter state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_ADDR_TX  = 2'b00,
    UART_ADDR_RX  = 2'b01,
    UART_ADDR_DIV = 2'b10
  } uart_addr_t;

  // The UART uses the opposite write polarity from the requesters.
  localparam logic UART_WE_WRITE = 1'b0;
  localparam logic UART_WE_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_RELEASE,
    ST_DONE,
    ST_GAP
  } arb_state_t;

endpackage

// File: rtl/uart_wb_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the UART register port.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface uart_wb_arbiter_if;

  logic       m0_stb, m1_stb;
  logic       m0_we, m1_we;
  logic [1:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_ack, m1_ack;
  logic       m0_err, m1_err;
  logic [7:0] m0_rdata, m1_rdata;

  logic       u_stb;
  logic       u_clk;
  logic       u_we;
  logic [1:0] u_addr;
  logic [7:0] u_data_in;
  logic [7:0] u_data_out;
  logic       u_ack;

  logic       grant;
  logic       busy;

  modport slave (
    input  m0_stb, m1_stb, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    output u_stb, u_clk, u_we, u_addr, u_data_in,
    input  u_data_out, u_ack,
    output grant, busy
  );

  modport master (
    output m0_stb, m1_stb, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    input  u_stb, u_clk, u_we, u_addr, u_data_in,
    output u_data_out, u_ack,
    input  grant, busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone request wins, a tie goes to
// the master that was not granted last.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic gnt
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      gnt = ~last_grant;
    end else begin
      gnt = req1;
    end
  end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Two-master arbiter and handshake sequencer for the UART register port, with
// a per-wait-state timeout that turns a hung transfer into an error completion.
module uart_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  uart_wb_arbiter_if.slave bus
);

  import uart_pkg::*;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t state, next_state;
  logic       err_flag, next_err;
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  logic       last_grant;
  logic       arb_valid, arb_gnt;
  logic       grant_taken, done_entry;
  logic       sel_we;
  logic [1:0] sel_addr;
  logic [7:0] sel_wdata;

  rr_arbiter2 u_rr (
    .req0       (bus.m0_stb),
    .req1       (bus.m1_stb),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .gnt        (arb_gnt)
  );

  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign grant_taken = (state == ST_IDLE) && (next_state == ST_STROBE);
  assign done_entry  = (state == ST_RELEASE) && (next_state == ST_DONE);
  assign sel_we      = arb_gnt ? bus.m1_we    : bus.m0_we;
  assign sel_addr    = arb_gnt ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata   = arb_gnt ? bus.m1_wdata : bus.m0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      err_flag <= 1'b0;
    end else begin
      state    <= next_state;
      err_flag <= next_err;
    end
  end

  // A new grant is held off while the UART still shows an ack from a transfer
  // that ended by timeout, so strobe never rises onto a stale ack.
  always_comb begin
    next_state = state;
    next_err   = err_flag;
    unique case (state)
      ST_IDLE: begin
        if (arb_valid && !bus.u_ack) begin
          next_state = ST_STROBE;
          next_err   = 1'b0;
        end
      end
      ST_STROBE: begin
        if (bus.u_ack) begin
          next_state = ST_RELEASE;
        end else if (tmo_hit) begin
          next_state = ST_RELEASE;
          next_err   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!bus.u_ack) begin
          next_state = ST_DONE;
        end else if (tmo_hit) begin
          next_state = ST_DONE;
          next_err   = 1'b1;
        end
      end
      ST_DONE: next_state = ST_GAP;
      ST_GAP:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || (next_state != state)) begin
      tmo_cnt <= 8'd0;
    end else if ((state == ST_STROBE) || (state == ST_RELEASE)) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // The UART address/data/polarity registers double as the request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.u_stb     <= 1'b0;
      bus.u_clk     <= 1'b0;
      bus.u_we      <= 1'b0;
      bus.u_addr    <= 2'b00;
      bus.u_data_in <= 8'h00;
      bus.busy      <= 1'b0;
      bus.grant     <= 1'b0;
      last_grant    <= 1'b1;
      bus.m0_ack    <= 1'b0;
      bus.m1_ack    <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.m0_rdata  <= 8'h00;
      bus.m1_rdata  <= 8'h00;
    end else begin
      bus.u_stb  <= (next_state == ST_STROBE);
      bus.u_clk  <= (next_state == ST_STROBE);
      bus.busy   <= (next_state != ST_IDLE);
      bus.m0_ack <= done_entry && !bus.grant;
      bus.m1_ack <= done_entry && bus.grant;
      bus.m0_err <= done_entry && !bus.grant && next_err;
      bus.m1_err <= done_entry && bus.grant && next_err;
      if (grant_taken) begin
        bus.grant     <= arb_gnt;
        last_grant    <= arb_gnt;
        bus.u_we      <= sel_we ? UART_WE_WRITE : UART_WE_READ;
        bus.u_addr    <= sel_addr;
        bus.u_data_in <= sel_wdata;
      end
      if (done_entry) begin
        if (next_err) begin
          if (bus.grant) bus.m1_rdata <= 8'h00;
          else           bus.m0_rdata <= 8'h00;
        end else if (bus.u_we == UART_WE_READ) begin
          if (bus.grant) bus.m1_rdata <= bus.u_data_out;
          else           bus.m0_rdata <= bus.u_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed and randomized bench for uart_wb_arbiter against a simple UART
// responder and a transaction-level model of who gets served and what data.
module tb_uart_wb_arbiter;

  import uart_pkg::*;

  localparam int TMO = 10;

  logic clk = 1'b0;
  logic reset;

  uart_wb_arbiter_if bus ();

  uart_wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         uart_mute  = 1'b0;
  bit         uart_stick = 1'b0;
  int         xfer_count = 0;
  logic       prev_stb   = 1'b0;
  logic [7:0] exp_rdata [2];
  bit         model_last;

  // UART responder: acks one cycle after it sees stb&clk; can be muted or made to hold ack.
  always @(posedge clk) begin
    if (reset)           bus.u_ack <= 1'b0;
    else if (uart_mute)  bus.u_ack <= 1'b0;
    else if (uart_stick) bus.u_ack <= bus.u_ack | (bus.u_stb & bus.u_clk);
    else                 bus.u_ack <= bus.u_stb & bus.u_clk;
  end

  always @(negedge clk) begin
    if (bus.u_stb === 1'b1 && prev_stb !== 1'b1) xfer_count <= xfer_count + 1;
    prev_stb <= bus.u_stb;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit m, input bit stb, input bit we,
                               input logic [1:0] addr, input logic [7:0] wdata);
    if (m) begin
      bus.m1_stb = stb; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_stb = stb; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  function automatic logic ackOf(input bit m);
    return m ? bus.m1_ack : bus.m0_ack;
  endfunction

  function automatic logic errOf(input bit m);
    return m ? bus.m1_err : bus.m0_err;
  endfunction

  function automatic logic [7:0] rdataOf(input bit m);
    return m ? bus.m1_rdata : bus.m0_rdata;
  endfunction

  // Issue a request from an IDLE negedge, check the UART-side request, then wait for ack.
  task automatic doTransfer(input bit m, input bit we, input logic [1:0] addr,
                            input logic [7:0] wdata, input int budget,
                            output int lat, output int stb_cycles);
    int   split;
    logic exp_uwe;
    logic exp_grant;
    split     = 0;
    exp_uwe   = we ? UART_WE_WRITE : UART_WE_READ;
    exp_grant = m;
    applyStimulus(m, 1'b1, we, addr, wdata);
    tick();
    lat        = 1;
    stb_cycles = 0;
    checkOutput("req_u_stb", bus.u_stb, 32'd1);
    checkOutput("req_u_we", bus.u_we, exp_uwe);
    checkOutput("req_u_addr", bus.u_addr, addr);
    checkOutput("req_grant", bus.grant, exp_grant);
    checkOutput("req_busy", bus.busy, 32'd1);
    if (we) checkOutput("req_u_data_in", bus.u_data_in, wdata);
    while (ackOf(m) !== 1'b1 && lat < budget) begin
      if (bus.u_stb === 1'b1) stb_cycles++;
      if (bus.u_stb !== bus.u_clk) split++;
      tick();
      lat++;
    end
    checkOutput("stb_clk_together", split, 32'd0);
    checkOutput("ack_within_budget", ackOf(m), 32'd1);
    model_last = m;
  endtask

  task automatic finishTransfer(input bit m);
    applyStimulus(m, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();
    checkOutput("ack_pulse_one_cycle", ackOf(m), 32'd0);
    tick();
  endtask

  initial begin
    int         lat, sc, acks, last_c, x0, seen;
    bit         exp_m;
    logic       got;
    logic [7:0] uval;
    bit         rm, rwe;
    logic [1:0] raddr;
    logic [7:0] rwd;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    bus.u_data_out = 8'h00;
    model_last = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    $display("[TB] reset values");
    checkOutput("rst_busy", bus.busy, 32'd0);
    checkOutput("rst_u_stb", bus.u_stb, 32'd0);
    checkOutput("rst_u_clk", bus.u_clk, 32'd0);
    checkOutput("rst_u_we", bus.u_we, 32'd0);
    checkOutput("rst_u_addr", bus.u_addr, 32'd0);
    checkOutput("rst_u_data_in", bus.u_data_in, 32'd0);
    checkOutput("rst_m0_rdata", bus.m0_rdata, 32'd0);
    checkOutput("rst_m1_rdata", bus.m1_rdata, 32'd0);
    checkOutput("rst_grant", bus.grant, 32'd0);
    checkOutput("rst_m0_ack", bus.m0_ack, 32'd0);
    checkOutput("rst_m1_ack", bus.m1_ack, 32'd0);
    checkOutput("rst_m0_err", bus.m0_err, 32'd0);
    checkOutput("rst_m1_err", bus.m1_err, 32'd0);
    tick();

    $display("[TB] first tie goes to m0; m0 writes 0x55 to TX");
    applyStimulus(1'b1, 1'b1, 1'b0, UART_ADDR_RX, 8'h00);
    doTransfer(1'b0, 1'b1, UART_ADDR_TX, 8'h55, 20, lat, sc);
    checkOutput("wr_latency", lat, 32'd5);
    checkOutput("wr_stb_cycles", sc, 32'd2);
    checkOutput("wr_err", bus.m0_err, 32'd0);
    checkOutput("wr_rdata_kept", bus.m0_rdata, 32'd0);
    checkOutput("wr_no_m1_ack", bus.m1_ack, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    finishTransfer(1'b0);

    $display("[TB] m1 reads RX, UART returns 0x41");
    bus.u_data_out = 8'h41;
    doTransfer(1'b1, 1'b0, UART_ADDR_RX, 8'h00, 20, lat, sc);
    checkOutput("rd_latency", lat, 32'd5);
    checkOutput("rd_err", bus.m1_err, 32'd0);
    checkOutput("rd_rdata", bus.m1_rdata, 32'h41);
    finishTransfer(1'b1);

    $display("[TB] both masters request continuously");
    uval = 8'($urandom_range(1, 255));
    bus.u_data_out = uval;
    applyStimulus(1'b0, 1'b1, 1'b0, UART_ADDR_RX, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, UART_ADDR_RX, 8'h00);
    exp_m  = !model_last;
    acks   = 0;
    last_c = 0;
    for (int c = 1; c <= 40 && acks < 4; c++) begin
      tick();
      if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
        got = bus.m1_ack;
        checkOutput("rr_order", got, exp_m);
        checkOutput("rr_single_ack", bus.m0_ack & bus.m1_ack, 32'd0);
        if (acks > 0) checkOutput("rr_spacing", c - last_c, 32'd7);
        else          checkOutput("rr_first_latency", c, 32'd5);
        checkOutput("rr_rdata", rdataOf(got), uval);
        exp_rdata[got] = uval;
        last_c     = c;
        acks++;
        model_last = got;
        exp_m      = !got;
        uval       = 8'($urandom_range(1, 255));
        bus.u_data_out = uval;
      end
    end
    checkOutput("rr_ack_count", acks, 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();
    tick();

    $display("[TB] UART never acks: strobe-phase timeout");
    uart_mute = 1'b1;
    doTransfer(1'b0, 1'b0, UART_ADDR_RX, 8'h00, 40, lat, sc);
    checkOutput("tmo_latency", lat, 32'd12);
    checkOutput("tmo_stb_cycles", sc, 32'd10);
    checkOutput("tmo_err", bus.m0_err, 32'd1);
    checkOutput("tmo_rdata_zero", bus.m0_rdata, 32'd0);
    uart_mute = 1'b0;
    finishTransfer(1'b0);
    doTransfer(1'b0, 1'b1, UART_ADDR_DIV, 8'h07, 20, lat, sc);
    checkOutput("post_tmo_latency", lat, 32'd5);
    checkOutput("post_tmo_err", bus.m0_err, 32'd0);
    finishTransfer(1'b0);

    $display("[TB] UART holds ack: release-phase timeout");
    uart_stick = 1'b1;
    doTransfer(1'b1, 1'b0, UART_ADDR_RX, 8'h00, 40, lat, sc);
    checkOutput("rel_tmo_latency", lat, 32'd13);
    checkOutput("rel_tmo_stb_cycles", sc, 32'd2);
    checkOutput("rel_tmo_err", bus.m1_err, 32'd1);
    checkOutput("rel_tmo_rdata_zero", bus.m1_rdata, 32'd0);
    uart_stick = 1'b0;
    finishTransfer(1'b1);
    tick();

    $display("[TB] reset while in RELEASE");
    applyStimulus(1'b0, 1'b1, 1'b1, UART_ADDR_TX, 8'h12);
    repeat (3) tick();
    checkOutput("pre_rst_busy", bus.busy, 32'd1);
    checkOutput("pre_rst_u_stb", bus.u_stb, 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();
    checkOutput("mid_rst_busy", bus.busy, 32'd0);
    checkOutput("mid_rst_u_stb", bus.u_stb, 32'd0);
    checkOutput("mid_rst_u_clk", bus.u_clk, 32'd0);
    checkOutput("mid_rst_m0_ack", bus.m0_ack, 32'd0);
    reset = 1'b0;
    model_last   = 1'b1;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.m0_ack === 1'b1) seen++;
    end
    checkOutput("aborted_no_ack", seen, 32'd0);
    uval = 8'($urandom);
    bus.u_data_out = uval;
    doTransfer(1'b1, 1'b0, UART_ADDR_RX, 8'h00, 20, lat, sc);
    checkOutput("after_rst_latency", lat, 32'd5);
    checkOutput("after_rst_rdata", bus.m1_rdata, uval);
    exp_rdata[1] = uval;
    finishTransfer(1'b1);

    $display("[TB] registered master holds stb past ack");
    x0 = xfer_count;
    doTransfer(1'b0, 1'b1, UART_ADDR_TX, 8'hA5, 20, lat, sc);
    checkOutput("hold_latency", lat, 32'd5);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.m0_ack === 1'b1) seen++;
    end
    checkOutput("hold_extra_acks", seen, 32'd0);
    checkOutput("hold_xfer_count", xfer_count - x0, 32'd1);

    $display("[TB] randomized single transfers");
    for (int i = 0; i < 24; i++) begin
      rm    = 1'($urandom_range(0, 1));
      rwe   = 1'($urandom_range(0, 1));
      raddr = 2'($urandom_range(0, 2));
      rwd   = 8'($urandom);
      uval  = 8'($urandom);
      bus.u_data_out = uval;
      doTransfer(rm, rwe, raddr, rwd, 20, lat, sc);
      checkOutput("rnd_latency", lat, 32'd5);
      checkOutput("rnd_err", errOf(rm), 32'd0);
      if (!rwe) exp_rdata[rm] = uval;
      checkOutput("rnd_rdata_m0", bus.m0_rdata, exp_rdata[0]);
      checkOutput("rnd_rdata_m1", bus.m1_rdata, exp_rdata[1]);
      finishTransfer(rm);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_wb_arbiter.md
# uart_wb_arbiter

Two-requester arbiter and bus sequencer in front of the UART register port (TX data 0x0, RX data 0x1, frequency divider 0x2). It accepts single-beat read/write requests from two masters (m0: CPU, m1: debug loader), grants one at a time with round-robin fairness, and drives the UART's level-based strobe/`wb_clk`/ack handshake. A timeout converts a hung UART transaction into an error response instead of a bus lockup.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles allowed in each UART wait state before abort; must be 1..255.
- `clk` in 1: system clock; same clock as the UART.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `m0_stb`, `m1_stb` in 1: request; held high until the matching `mX_ack`.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read (requester polarity).
- `m0_addr`, `m1_addr` in 2: UART register address.
- `m0_wdata`, `m1_wdata` in 8: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: valid with ack; 1 = timeout.
- `m0_rdata`, `m1_rdata` out 8: read data, valid with ack; held until next completion to that master.
- `u_stb` out 1: UART strobe.
- `u_clk` out 1: UART transfer qualifier (`wb_clk`).
- `u_we` out 1: UART polarity, 0 = write, 1 = read (inverse of `mX_we`).
- `u_addr` out 2; `u_data_in` out 8: to UART.
- `u_data_out` in 8; `u_ack` in 1: from UART.
- `grant` out 1: index of current or last granted master.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, STROBE, RELEASE, DONE, GAP.
- IDLE: if any `mX_stb` is high, grant and latch we/addr/wdata, then go to STROBE. Later changes on master inputs are ignored until DONE.
- Arbitration: a single request wins. If both request, grant `!last_grant`. `last_grant` updates on each grant; its reset value is 1, so m0 wins the first tie.
- STROBE: `u_stb=1`, `u_clk=1`, with `u_we/u_addr/u_data_in` from the latch. On `u_ack==1`, go to RELEASE.
- RELEASE: `u_stb=0`, `u_clk=0`, outputs otherwise held. On `u_ack==0`, capture `u_data_out` into the granted master's rdata (reads only; writes leave rdata unchanged) and go to DONE.
- DONE: pulse the granted `mX_ack` for one cycle, with `mX_err=0`, then go to GAP.
- GAP: one cycle with no arbitration, which absorbs a registered master's stale stb. Then go to IDLE.
- Timeout: an 8-bit counter clears on entry to STROBE and RELEASE and increments every cycle in those states. When it reaches `TIMEOUT_CYCLES` in STROBE, go to RELEASE with an error flag set. When it reaches `TIMEOUT_CYCLES` in RELEASE, go to DONE with the error flag set.
  - An errored DONE asserts `mX_err=1` with ack.
  - On an error, rdata is forced to 0x00.
- Reset mid-transaction: return to IDLE at once and drop all outputs. The aborted master receives no ack.
- Reset values: all acks, errs, `u_stb`, `u_clk`, `u_we`, and `busy` are 0. `u_addr=0`, `u_data_in=0`, all rdata 0x00, `grant=0`, `last_grant=1`.

## Timing
- Outputs are registered. Nominal read or write with a UART that acks one cycle after it sees stb&clk:
  - Request seen at cycle 0.
  - `u_stb/u_clk` high in cycles 1–2.
  - RELEASE in cycles 3–4.
  - `mX_ack` in cycle 5.
  - GAP in cycle 6.
- Back-to-back throughput is one transaction per 7 cycles.
- Read data is sampled in the cycle the arbiter sees `u_ack` low. At that point the UART's READ_ACK has refreshed `wb_data_out` with the post-pop FIFO head.
- `u_stb` and `u_clk` always rise and fall together. Neither is asserted while `u_ack` is still high from a previous transfer.
- A master that deasserts `stb` before ack creates an orphaned transfer: the transfer still completes and the ack pulse is still issued.

## Structure
- Shared package `uart_pkg`: register addresses (TX=2'b00, RX=2'b01, DIV=2'b10), UART write/read `we` polarity constants, and the arbiter state encoding.
- Natural sub-module: `rr_arbiter2`, a combinational grant from two requests plus `last_grant`. The FSM, latch, and timeout counter stay in the top.

## Test plan
- m0 writes 0x55 to addr 0 against a UART model:
  - `u_we=0`, `u_addr=0`, `u_data_in=0x55` while `u_stb` is high.
  - `m0_ack` in cycle 5 with `m0_err=0`.
- m1 reads addr 1 with the model returning 0x41: `m1_rdata=0x41` in the ack cycle, `u_we=1`.
- m0 and m1 both request continuously:
  - Grants alternate m0, m1, m0, m1.
  - Acks are 7 cycles apart.
  - No master is served twice in a row.
- UART never acks with `TIMEOUT_CYCLES=10`:
  - Abort after 10 STROBE cycles, then the RELEASE wait.
  - `m0_ack=1` with `m0_err=1` and `m0_rdata=0x00`.
  - The next request proceeds normally.
- Reset asserted in RELEASE: the next cycle shows IDLE, `u_stb=0`, `u_clk=0`, and no ack. A new m1 request then completes.
- Master holds `stb` one cycle past ack (registered master): GAP suppresses re-issue, so exactly one UART transfer occurs.
